// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained by execute-stage resolution.
// Lookup is combinational (zero latency). Updates commit at the clock edge. No backpressure: one update per cycle.
// Perf counters saturate at all-ones.
module branch_target_buffer #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_target,
    input  logic [31:0] ex_pc,
    input  logic        ex_update,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_mispredict,
    output logic [31:0] hit_count,
    output logic [31:0] mispredict_count
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  lookup_hit, ex_hit;

    logic        upd_en;
    logic [31:0] upd_target;
    logic [1:0]  upd_ctr;

    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // Instruction alignment bits carry no information for indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx = if_pc[2+INDEX_BITS-1:2];
    assign if_tag = if_pc[31:2+INDEX_BITS];
    assign ex_idx = ex_pc[2+INDEX_BITS-1:2];
    assign ex_tag = ex_pc[31:2+INDEX_BITS];

    assign lookup_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit           = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign predicted_taken  = lookup_hit && ctr_q[if_idx][1];
    assign predicted_target = lookup_hit ? target_q[if_idx] : 32'h0;

    // ex_* fields are only examined under ex_update, so garbage on them is harmless.
    always_comb begin
        upd_en     = 1'b0;
        upd_target = target_q[ex_idx];
        upd_ctr    = ctr_q[ex_idx];
        if (ex_update) begin
            if (ex_is_jump) begin
                upd_en     = 1'b1;
                upd_target = ex_target;
                upd_ctr    = 2'b11;
            end else if (ex_hit) begin
                upd_en = 1'b1;
                if (ex_taken) begin
                    upd_target = ex_target;
                    upd_ctr    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                end else begin
                    upd_ctr    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                upd_en     = 1'b1;
                upd_target = ex_target;
                upd_ctr    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= upd_target;
            ctr_q[ex_idx]    <= upd_ctr;
        end
    end

    assign hit_cnt_d = (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF))
                     ? hit_cnt_q + 32'd1 : hit_cnt_q;
    assign mispredict_cnt_d = (ex_update && ex_mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
                            ? mispredict_cnt_q + 32'd1 : mispredict_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q        <= 32'h0;
            mispredict_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q        <= hit_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign hit_count        = hit_cnt_q;
    assign mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: lookup, training, conflicts, same-cycle access, counters.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic        predicted_taken;
    logic [31:0] predicted_target;
    logic [31:0] ex_pc = 32'h0;
    logic        ex_update = 1'b0;
    logic        ex_is_jump = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_mispredict = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.INDEX_BITS(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .predicted_taken  (predicted_taken),
        .predicted_target (predicted_target),
        .ex_pc            (ex_pc),
        .ex_update        (ex_update),
        .ex_is_jump       (ex_is_jump),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_mispredict    (ex_mispredict),
        .hit_count        (hit_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ex_update = 1'b0;
        ex_mispredict = 1'b0;
        if_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one update for exactly one clock edge; returns at posedge+1.
    task automatic update(input logic [31:0] pc, input logic jump, input logic taken,
                          input logic [31:0] tgt, input logic mis);
        ex_pc = pc;
        ex_is_jump = jump;
        ex_taken = taken;
        ex_target = tgt;
        ex_mispredict = mis;
        ex_update = 1'b1;
        @(posedge clk);
        #1;
        ex_update = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    // Combinational lookup within one cycle, so hit_count is not disturbed.
    task automatic check_lookup(input string name, input logic [31:0] pc,
                                input logic exp_taken, input logic [31:0] exp_target);
        if_pc = pc;
        #1;
        checks++;
        if (predicted_taken !== exp_taken) begin
            errors++;
            $display("FAIL %s_taken: got %0b expected %0b", name, predicted_taken, exp_taken);
        end
        checks++;
        if (predicted_target !== exp_target) begin
            errors++;
            $display("FAIL %s_target: got %h expected %h", name, predicted_target, exp_target);
        end
        if_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_pc = 32'h100;
        ex_pc = 32'h100;
        ex_taken = 1'b1;
        ex_target = 32'h80;
        ex_update = 1'b1;
        ex_mispredict = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ex_update = 1'b0;
        ex_mispredict = 1'b0;
        rst_n = 1'b1;
        check_lookup("reset_lookup", 32'h100, 1'b0, 32'h0);
        checks++;
        if (hit_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_hit_count: got %h expected 0", hit_count);
        end
        checks++;
        if (mispredict_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_mispredict_count: got %h expected 0", mispredict_count);
        end
    endtask

    task automatic test_allocate();
        do_reset();
        update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        check_lookup("alloc", 32'h100, 1'b1, 32'h80);
        // Hold a hitting lookup across exactly one edge.
        if_pc = 32'h100;
        @(posedge clk);
        #1 if_pc = 32'h0;
        checks++;
        if (hit_count !== 32'd1) begin
            errors++;
            $display("FAIL alloc_hit_count: got %0d expected 1", hit_count);
        end
        update(32'h104, 1'b0, 1'b0, 32'h99, 1'b0);
        check_lookup("miss_not_taken_no_alloc", 32'h104, 1'b0, 32'h0);
    endtask

    // Continues from the 0x100 entry at ctr=10 left by test_allocate.
    task automatic test_hysteresis();
        update(32'h100, 1'b0, 1'b0, 32'hDEAD, 1'b0);
        check_lookup("hyst_ctr01", 32'h100, 1'b0, 32'h80);
        update(32'h100, 1'b0, 1'b0, 32'hDEAD, 1'b0);
        check_lookup("hyst_ctr00_valid_kept", 32'h100, 1'b0, 32'h80);
        update(32'h100, 1'b0, 1'b0, 32'hDEAD, 1'b0);
        update(32'h100, 1'b0, 1'b1, 32'h84, 1'b0);
        check_lookup("hyst_floor_then_ctr01", 32'h100, 1'b0, 32'h84);
        update(32'h100, 1'b0, 1'b1, 32'h88, 1'b0);
        check_lookup("hyst_ctr10", 32'h100, 1'b1, 32'h88);
        update(32'h100, 1'b0, 1'b1, 32'h88, 1'b0);
        update(32'h100, 1'b0, 1'b1, 32'h88, 1'b0);
        update(32'h100, 1'b0, 1'b0, 32'h88, 1'b0);
        check_lookup("hyst_sat11_then_ctr10", 32'h100, 1'b1, 32'h88);
        update(32'h100, 1'b0, 1'b0, 32'h88, 1'b0);
        check_lookup("hyst_back_to_ctr01", 32'h100, 1'b0, 32'h88);
    endtask

    task automatic test_conflict();
        update(32'h140, 1'b1, 1'b1, 32'h200, 1'b0);
        check_lookup("conflict_old", 32'h100, 1'b0, 32'h0);
        check_lookup("conflict_new", 32'h140, 1'b1, 32'h200);
        check_lookup("conflict_low_bits", 32'h143, 1'b1, 32'h200);
        // Jump installs ctr=11, so one not-taken branch keeps it predicting taken.
        update(32'h140, 1'b0, 1'b0, 32'h0, 1'b0);
        check_lookup("jump_ctr11_to_10", 32'h140, 1'b1, 32'h200);
    endtask

    task automatic test_same_cycle();
        do_reset();
        if_pc = 32'h300;
        ex_pc = 32'h300;
        ex_is_jump = 1'b0;
        ex_taken = 1'b1;
        ex_target = 32'h340;
        ex_update = 1'b1;
        #1;
        checks++;
        if (predicted_taken !== 1'b0 || predicted_target !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_pre: got %0b/%h expected 0/0", predicted_taken, predicted_target);
        end
        @(posedge clk);
        #1 ex_update = 1'b0;
        checks++;
        if (predicted_taken !== 1'b1 || predicted_target !== 32'h340) begin
            errors++;
            $display("FAIL same_cycle_post: got %0b/%h expected 1/340", predicted_taken, predicted_target);
        end
        if_pc = 32'h0;
        checks++;
        if (hit_count !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle_hit_count: got %0d expected 0", hit_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_pc = 32'h500;
        ex_is_jump = 1'b0;
        ex_taken = 1'b1;
        ex_target = 32'h10;
        ex_update = 1'b1;
        @(posedge clk);
        #1;
        ex_taken = 1'b0;
        ex_target = 32'h20;
        @(posedge clk);
        #1 ex_update = 1'b0;
        check_lookup("b2b_chain", 32'h500, 1'b0, 32'h10);
    endtask

    task automatic test_async_reset();
        update(32'h500, 1'b0, 1'b1, 32'h30, 1'b0);
        check_lookup("async_pre", 32'h500, 1'b1, 32'h30);
        if_pc = 32'h500;
        ex_pc = 32'h704;
        ex_taken = 1'b1;
        ex_target = 32'h44;
        ex_update = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (predicted_taken !== 1'b0 || predicted_target !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %0b/%h expected 0/0", predicted_taken, predicted_target);
        end
        @(posedge clk);
        #1;
        ex_update = 1'b0;
        rst_n = 1'b1;
        check_lookup("async_pending_discarded", 32'h704, 1'b0, 32'h0);
    endtask

    task automatic test_counters();
        do_reset();
        for (int i = 0; i < 3; i++) update(32'h600, 1'b0, 1'b0, 32'h0, 1'b1);
        ex_pc = 'x;
        ex_is_jump = 'x;
        ex_taken = 'x;
        ex_target = 'x;
        ex_mispredict = 1'b1;
        @(posedge clk);
        #1 ex_mispredict = 1'b0;
        checks++;
        if (mispredict_count !== 32'd3) begin
            errors++;
            $display("FAIL mispredict_count: got %0d expected 3", mispredict_count);
        end
        check_lookup("mis_no_alloc", 32'h600, 1'b0, 32'h0);

        force dut.mispredict_cnt_d = 32'hFFFF_FFFE;
        @(posedge clk);
        #1 release dut.mispredict_cnt_d;
        checks++;
        if (mispredict_count !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL mis_preload: got %h expected fffffffe", mispredict_count);
        end
        update(32'h600, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mispredict_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mis_reach_max: got %h expected ffffffff", mispredict_count);
        end
        update(32'h600, 1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (mispredict_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mis_saturate: got %h expected ffffffff", mispredict_count);
        end

        update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        force dut.hit_cnt_d = 32'hFFFF_FFFE;
        @(posedge clk);
        #1 release dut.hit_cnt_d;
        if_pc = 32'h100;
        repeat (3) @(posedge clk);
        #1 if_pc = 32'h0;
        checks++;
        if (hit_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL hit_saturate: got %h expected ffffffff", hit_count);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_conflict();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        test_counters();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
